// File: rtl/core_fetch_unit.sv
// In-order instruction fetch: PC, request credit, in-flight PC queue, response FIFO, redirect flush.
// state | meaning: S_IDLE one cycle after reset | S_RUN normal fetch | S_DRAIN discarding stale responses
module core_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = CW + 4;
  localparam logic [CW:0] DEPTH_L = DEPTH[CW:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    pc_q, pc_d;
  logic [CW-1:0]  out_q, out_d;
  logic [DW-1:0]  drop_q, drop_d;
  logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]  fifo_rd_q, fifo_rd_d;
  logic [AW-1:0]  fifo_wr_q, fifo_wr_d;
  logic [AW-1:0]  pcq_rd_q, pcq_rd_d;
  logic [AW-1:0]  pcq_wr_q, pcq_wr_d;

  logic [31:0]    fifo_data_q [DEPTH];
  logic [63:0]    fifo_pc_q   [DEPTH];
  logic [63:0]    pcq_q       [DEPTH];

  logic           credit_ok;
  logic           req_fire;
  logic           resp_drop;
  logic           push;
  logic           pop;
  logic [DW-1:0]  stale_cnt;
  logic           unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign credit_ok      = ({1'b0, out_q} + {1'b0, fifo_cnt_q}) < DEPTH_L;
  assign imem_req_valid = (state_q != S_IDLE) && fetch_en && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding and nothing to drop are ignored.
  assign resp_drop = !redirect_valid && imem_resp_valid && (drop_q != '0);
  assign push      = !redirect_valid && imem_resp_valid && (drop_q == '0) && (out_q != '0);
  assign pop       = !redirect_valid && instr_valid && instr_ready;

  assign instr_valid = (fifo_cnt_q != '0);
  assign instr       = instr_valid ? fifo_data_q[fifo_rd_q] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc_q[fifo_rd_q]   : 64'h0;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    fifo_cnt_d = fifo_cnt_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    pcq_rd_d   = pcq_rd_q;
    pcq_wr_d   = pcq_wr_q;
    stale_cnt  = '0;

    if (redirect_valid) begin
      // Everything in flight becomes stale; the response arriving this cycle is one of them.
      stale_cnt = {{(DW-CW){1'b0}}, out_q} + drop_q;
      if (imem_resp_valid && (stale_cnt != '0)) begin
        stale_cnt = stale_cnt - DW'(1);
      end
      drop_d     = stale_cnt;
      out_d      = '0;
      pc_d       = {redirect_pc[63:2], 2'b00};
      fifo_cnt_d = '0;
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      pcq_rd_d   = '0;
      pcq_wr_d   = '0;
      state_d    = (stale_cnt != '0) ? S_DRAIN : S_RUN;
    end else begin
      if (req_fire) begin
        pc_d     = pc_q + 64'd4;
        pcq_wr_d = pcq_wr_q + AW'(1);
      end
      if (resp_drop) begin
        drop_d = drop_q - DW'(1);
      end
      if (push) begin
        pcq_rd_d  = pcq_rd_q + AW'(1);
        fifo_wr_d = fifo_wr_q + AW'(1);
      end
      if (pop) begin
        fifo_rd_d = fifo_rd_q + AW'(1);
      end

      case ({req_fire, push})
        2'b10:   out_d = out_q + CW'(1);
        2'b01:   out_d = out_q - CW'(1);
        default: out_d = out_q;
      endcase

      case ({push, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
        default: fifo_cnt_d = fifo_cnt_q;
      endcase

      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_DRAIN: state_d = (drop_d == '0) ? S_RUN : S_DRAIN;
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      fifo_cnt_q <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_wr_q   <= pcq_wr_d;
    end
  end

  // Storage needs no reset: entries are only read once the matching count says they are valid.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_q[pcq_wr_q] <= pc_q;
    end
    if (push) begin
      fifo_data_q[fifo_wr_q] <= imem_resp_data;
      fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
    end
  end

endmodule
